sensor_iman: RTL
================

Name: sensor_iman

Overview:
- Front end for the speedometer's reed/magnet wheel sensor; produces the single-cycle `impulsoIman` pulse that the distance accumulator consumes.
- Synchronizes and debounces the raw switch, then emits one pulse per wheel revolution.
- Measures the revolution period in clock cycles and counts revolutions.
- Flags a stopped wheel on timeout so downstream speed logic can force zero.

Parameters:
- DEB_CYC, 50000, consecutive stable cycles required to accept a new switch level (1 ms at 50 MHz).
- TIMEOUT_CYC, 150000000, cycles without a pulse before the wheel is declared stopped (3 s).
- PERIOD_W, 32, width of the period counter/output; must hold TIMEOUT_CYC.
- SIM_DIV, 2500000, internal generator pulse interval in cycles (used only with SIM_GEN_EN).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iman_raw  in  1  raw reed-switch level, asynchronous to clock, bouncy.
- impulsoIman  out  1  one-clock pulse per accepted revolution.
- periodo  out  PERIOD_W  cycles between the last two pulses; 0 when stopped.
- periodo_valido  out  1  one-clock strobe when `periodo` updates with a new measurement.
- detenido  out  1  high while no valid period exists (after reset or after timeout).
- vueltas  out  16  revolution count, wraps 65535 -> 0.

Behaviour:
- Reset (asynchronous, any time): state ESPERA, `detenido`=1, all other outputs 0, and all counters, synchronizer flops and the filtered level cleared to 0. Reset mid-measurement discards the partial period.
- Synchronizer: two flops on `iman_raw`.
- Debounce:
  - Counter compares the synchronized level with the filtered level.
  - Counter clears on any mismatch change and on match.
  - After DEB_CYC consecutive mismatching cycles, the filtered level takes the new value.
- Edge detect: a 0->1 filtered transition asserts `impulsoIman` for exactly 1 cycle.
- Latency: `impulsoIman` rises DEB_CYC+3 rising edges after the first edge that samples `iman_raw`=1, provided raw stays high throughout. A 1->0 transition produces no pulse.
- Period counter:
  - Clears to 0 on each pulse and increments every cycle otherwise.
  - Saturates at TIMEOUT_CYC.
  - For pulses at cycles t0 and t1, the measured period is t1-t0.
- FSM:
  - ESPERA: waits for the first pulse. Pulse -> MIDIENDO; no strobe; `detenido` stays 1.
  - MIDIENDO:
    - Pulse -> `periodo`=t1-t0 and `periodo_valido`=1 for 1 cycle (both registered, visible the cycle after the pulse); `detenido`=0; stay in MIDIENDO.
    - Counter reaching TIMEOUT_CYC-1 with no pulse that cycle -> DETENIDO.
  - DETENIDO: `detenido`=1 and `periodo`=0, both set on entry. Pulse -> MIDIENDO with no strobe; it only acts as the new reference.
- Simultaneous timeout and pulse in the same cycle: the pulse wins. `periodo`=TIMEOUT_CYC, strobe issued, state stays MIDIENDO.
- `vueltas`: increments on every `impulsoIman` in any state, modulo 2^16.
- `periodo` holds its value between strobes.

Optional Feature:
- Macro: SENSOR_IMAN_SIM_GEN_EN.
- Defined:
  - `iman_raw` is ignored and the synchronizer/debounce path is not instantiated.
  - An internal counter drives the edge stage directly, giving one pulse every SIM_DIV cycles. The first pulse comes SIM_DIV cycles after reset release.
  - The FSM, period and count logic are unchanged, so `periodo`=SIM_DIV from the second pulse on.
  - Used for bench and board demos without a wheel.
- Undefined: normal raw-input path only; SIM_DIV unused.

Test Plan:
All scenarios use DEB_CYC=4, TIMEOUT_CYC=100, PERIOD_W=8.
- Reset behaviour: assert reset mid-count, then release -> `detenido`=1 and `periodo`=0, `periodo_valido`=0, `vueltas`=0, `impulsoIman`=0 immediately, without waiting for a clock edge.
- Clean edge: `iman_raw` 0->1 and held 20 cycles -> exactly one `impulsoIman` pulse, 7 edges after the first high sample; `vueltas`=1; no `periodo_valido` (ESPERA -> MIDIENDO).
- Bounce rejection: raw toggles high 2 cycles, low 1 cycle, high 3 cycles, then low -> no pulse and `vueltas` unchanged. Afterwards hold high 10 cycles -> exactly one pulse.
- Period measurement: clean pulses with their `impulsoIman` outputs 40 cycles apart, then 25 apart -> `periodo`=40 with one strobe, then `periodo`=25 with one strobe; `detenido` falls to 0 with the first strobe.
- Timeout and restart: after a pulse, no activity for 100 cycles -> `detenido`=1, `periodo`=0, no strobe. Next pulse gives no strobe; the pulse 30 cycles later gives `periodo`=30 and `detenido`=0.
- Boundary: second pulse exactly 100 cycles after the first -> `periodo`=100, strobe asserted, `detenido` remains 0. With SENSOR_IMAN_SIM_GEN_EN and SIM_DIV=16 -> pulses every 16 cycles and `periodo`=16.

Source files
------------

// File: rtl/sensor_iman.sv
// sensor_iman: wheel reed-switch front end for the speedometer.
// Synchronizes and debounces the raw switch, emits one impulsoIman pulse per
// revolution, measures the revolution period and counts revolutions. It
// flags a stopped wheel when no pulse arrives before the timeout.
// Optional build macro SENSOR_IMAN_SIM_GEN_EN: replaces the switch path with an
// internal pulse generator (one pulse every SIM_DIV cycles) for demos.
module sensor_iman #(
  parameter int DEB_CYC     = 50000,
  parameter int TIMEOUT_CYC = 150000000,
  parameter int PERIOD_W    = 32
`ifdef SENSOR_IMAN_SIM_GEN_EN
  , parameter int SIM_DIV   = 2500000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iman_raw,
  output logic                impulsoIman,
  output logic [PERIOD_W-1:0] periodo,
  output logic                periodo_valido,
  output logic                detenido,
  output logic [15:0]         vueltas
);

  typedef enum logic [1:0] {ESPERA, MIDIENDO, DETENIDO} state_t;

  // Rising edge of the accepted level, registered into pulse_q below.
  logic pulse_d;
  logic pulse_q;

`ifdef SENSOR_IMAN_SIM_GEN_EN
  localparam int GEN_W = $clog2(SIM_DIV + 1);

  logic [GEN_W-1:0] gen_cnt_q;

  // Free-running divider; its terminal count stands in for a filtered rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 gen_cnt_q <= '0;
    else if (gen_cnt_q == GEN_W'(SIM_DIV - 1)) gen_cnt_q <= '0;
    else                                       gen_cnt_q <= gen_cnt_q + 1'b1;
  end

  assign pulse_d = (gen_cnt_q == GEN_W'(SIM_DIV - 1));
`else
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_dly_q;
  logic [DEB_W-1:0] deb_cnt_q;

  // Two-flop synchronizer for the asynchronous switch level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= iman_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept the new level only after DEB_CYC consecutive mismatches.
  // A level that flips back to the filtered one restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
      filt_q    <= sync2_q;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  // Delayed copy of the filtered level for 0->1 detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) filt_dly_q <= 1'b0;
    else       filt_dly_q <= filt_q;
  end

  assign pulse_d = filt_q & ~filt_dly_q;
`endif

  logic [PERIOD_W-1:0] per_cnt_q;
  logic [PERIOD_W-1:0] periodo_q, periodo_d;
  logic                valido_q, valido_d;
  logic                det_q, det_d;
  logic [15:0]         vueltas_q;
  state_t              state_q, state_d;
  logic                timeout;

  // Registered revolution pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pulse_q <= 1'b0;
    else       pulse_q <= pulse_d;
  end

  // Cycles since the last pulse; the period is this count plus one on a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       per_cnt_q <= '0;
    else if (pulse_q)                                per_cnt_q <= '0;
    else if (per_cnt_q != PERIOD_W'(TIMEOUT_CYC))    per_cnt_q <= per_cnt_q + 1'b1;
  end

  // Revolution counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        vueltas_q <= '0;
    else if (pulse_q) vueltas_q <= vueltas_q + 1'b1;
  end

  assign timeout = (per_cnt_q == PERIOD_W'(TIMEOUT_CYC - 1));

  // Measurement FSM state and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ESPERA;
      periodo_q <= '0;
      valido_q  <= 1'b0;
      det_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      periodo_q <= periodo_d;
      valido_q  <= valido_d;
      det_q     <= det_d;
    end
  end

  // Next state: a pulse always beats a timeout landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    periodo_d = periodo_q;
    valido_d  = 1'b0;
    det_d     = det_q;
    case (state_q)
      ESPERA: begin
        if (pulse_q) state_d = MIDIENDO;
      end
      MIDIENDO: begin
        if (pulse_q) begin
          periodo_d = per_cnt_q + 1'b1;
          valido_d  = 1'b1;
          det_d     = 1'b0;
        end else if (timeout) begin
          state_d   = DETENIDO;
          periodo_d = '0;
          det_d     = 1'b1;
        end
      end
      DETENIDO: begin
        // First pulse after a stop is only a new reference point.
        if (pulse_q) state_d = MIDIENDO;
      end
      default: state_d = ESPERA;
    endcase
  end

  assign impulsoIman    = pulse_q;
  assign periodo        = periodo_q;
  assign periodo_valido = valido_q;
  assign detenido       = det_q;
  assign vueltas        = vueltas_q;

endmodule
